// File: rtl/multi_symbol_position_limiter.sv
// -----------------------------------------------------------------------------
// multi_symbol_position_limiter
//
// Pre-trade risk gate for a book of NUM_SYMBOLS instruments. Every accepted
// order is checked against the per-symbol net position, an order-size cap and
// a global gross-notional cap. One registered decision per accepted order is
// presented a cycle later. Positions and gross notional change only on fills.
//
// Ports
//   clk, rst_n                 clock, synchronous active-low reset
//   cfg_enabled                0: every in-range order passes (state still updates)
//   cfg_max_long_qty           largest allowed positive net position
//   cfg_max_short_qty          magnitude of the most negative allowed net position
//   cfg_max_order_qty          largest single new order
//   cfg_max_notional           global gross notional cap
//   order_*                    order request, valid/ready handshake
//   fill_*                     execution report, applied whenever fill_valid=1
//   result_*                   decision, valid/ready handshake
//   pos_rd_sym / pos_rd_net    combinational read of one registered net position
//   gross_notional             registered global gross notional
//   total_passed/rejected      count of decisions consumed downstream
// -----------------------------------------------------------------------------
package multi_symbol_position_limiter_pkg;

    typedef enum logic {
        SIDE_BUY  = 1'b0,
        SIDE_SELL = 1'b1
    } order_side_e;

    typedef enum logic {
        ORDER_NEW    = 1'b0,
        ORDER_CANCEL = 1'b1
    } order_type_e;

    typedef enum logic [1:0] {
        RISK_OK             = 2'd0,
        RISK_ORDER_SIZE     = 2'd1,
        RISK_POSITION_LIMIT = 2'd2,
        RISK_NOTIONAL_LIMIT = 2'd3
    } risk_reject_e;

endpackage

module multi_symbol_position_limiter
    import multi_symbol_position_limiter_pkg::*;
#(
    parameter int NUM_SYMBOLS    = 8,
    parameter int SYM_WIDTH      = (NUM_SYMBOLS > 1) ? $clog2(NUM_SYMBOLS) : 1,
    parameter int QTY_WIDTH      = 64,
    parameter int NOTIONAL_WIDTH = 64
) (
    input  logic                        clk,
    input  logic                        rst_n,

    input  logic                        cfg_enabled,
    input  logic [QTY_WIDTH-1:0]        cfg_max_long_qty,
    input  logic [QTY_WIDTH-1:0]        cfg_max_short_qty,
    input  logic [QTY_WIDTH-1:0]        cfg_max_order_qty,
    input  logic [NOTIONAL_WIDTH-1:0]   cfg_max_notional,

    input  logic                        order_valid,
    output logic                        order_ready,
    input  logic [SYM_WIDTH-1:0]        order_sym,
    input  order_side_e                 order_side,
    input  order_type_e                 order_type,
    input  logic [QTY_WIDTH-1:0]        order_qty,
    input  logic [NOTIONAL_WIDTH-1:0]   order_notional,

    input  logic                        fill_valid,
    input  logic [SYM_WIDTH-1:0]        fill_sym,
    input  order_side_e                 fill_side,
    input  logic [QTY_WIDTH-1:0]        fill_qty,
    input  logic [NOTIONAL_WIDTH-1:0]   fill_notional,

    output logic                        result_valid,
    input  logic                        result_ready,
    output logic                        result_passed,
    output risk_reject_e                result_reason,
    output logic [SYM_WIDTH-1:0]        result_sym,

    input  logic [SYM_WIDTH-1:0]        pos_rd_sym,
    output logic signed [QTY_WIDTH:0]   pos_rd_net,
    output logic [NOTIONAL_WIDTH-1:0]   gross_notional,

    output logic [63:0]                 total_passed,
    output logic [63:0]                 total_rejected
);

    // Two extra bits over the raw quantity: one for sign, one so that
    // net +/- qty can never wrap before it is compared or saturated.
    typedef logic signed [QTY_WIDTH+1:0] qty_ext_t;

    localparam qty_ext_t                 NET_MAX   = qty_ext_t'({QTY_WIDTH{1'b1}});
    localparam qty_ext_t                 NET_MIN   = -NET_MAX;
    localparam logic [SYM_WIDTH:0]       SYM_LIMIT = (SYM_WIDTH+1)'(NUM_SYMBOLS);

    logic signed [QTY_WIDTH:0]  net_q [NUM_SYMBOLS];
    logic [NOTIONAL_WIDTH-1:0]  gross_q;

    logic                       order_accept;
    logic                       order_in_range;
    logic                       fill_in_range;
    logic signed [QTY_WIDTH:0]  order_net;
    logic signed [QTY_WIDTH:0]  fill_net;
    logic signed [QTY_WIDTH:0]  rd_net;

    qty_ext_t                   order_net_x;
    qty_ext_t                   order_qty_x;
    qty_ext_t                   long_lim_x;
    qty_ext_t                   short_lim_x;
    qty_ext_t                   fill_net_x;
    qty_ext_t                   fill_qty_x;
    qty_ext_t                   fill_sum_x;
    logic signed [QTY_WIDTH:0]  fill_net_next;

    logic [NOTIONAL_WIDTH:0]    order_notional_sum;
    logic [NOTIONAL_WIDTH:0]    fill_notional_sum;
    logic [NOTIONAL_WIDTH-1:0]  gross_next;

    logic                       size_ok;
    logic                       position_ok;
    logic                       notional_ok;
    logic                       dec_passed;
    risk_reject_e               dec_reason;

    assign order_ready    = !result_valid || result_ready;
    assign order_accept   = order_valid && order_ready;
    assign order_in_range = {1'b0, order_sym} < SYM_LIMIT;
    assign fill_in_range  = {1'b0, fill_sym}  < SYM_LIMIT;

    // Read muxes over the position array. A loop compare keeps out-of-range
    // ids from indexing past the array; they simply read 0.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        order_net = '0;
        fill_net  = '0;
        rd_net    = '0;
        for (int i = 0; i < NUM_SYMBOLS; i++) begin
            if (order_sym  == SYM_WIDTH'(i)) order_net = net_q[i];
            if (fill_sym   == SYM_WIDTH'(i)) fill_net  = net_q[i];
            if (pos_rd_sym == SYM_WIDTH'(i)) rd_net    = net_q[i];
        end
    end

    assign pos_rd_net     = rd_net;
    assign gross_notional = gross_q;

    // Order checks, all on registered state so a same-cycle fill is invisible.
    always_comb begin
        order_net_x = qty_ext_t'(order_net);
        order_qty_x = {2'b00, order_qty};
        long_lim_x  = {2'b00, cfg_max_long_qty};
        short_lim_x = {2'b00, cfg_max_short_qty};

        size_ok = order_qty <= cfg_max_order_qty;
        if (order_side == SIDE_BUY) begin
            position_ok = (order_net_x + order_qty_x) <= long_lim_x;
        end else begin
            position_ok = (order_net_x - order_qty_x) >= -short_lim_x;
        end

        order_notional_sum = {1'b0, gross_q} + {1'b0, order_notional};
        notional_ok        = order_notional_sum <= {1'b0, cfg_max_notional};

        dec_passed = 1'b1;
        dec_reason = RISK_OK;
        if (!order_in_range) begin
            // Unknown instrument is rejected even when checking is disabled.
            dec_passed = 1'b0;
            dec_reason = RISK_POSITION_LIMIT;
        end else if (!cfg_enabled || order_type == ORDER_CANCEL) begin
            dec_passed = 1'b1;
            dec_reason = RISK_OK;
        end else if (!size_ok) begin
            dec_passed = 1'b0;
            dec_reason = RISK_ORDER_SIZE;
        end else if (!position_ok) begin
            dec_passed = 1'b0;
            dec_reason = RISK_POSITION_LIMIT;
        end else if (!notional_ok) begin
            dec_passed = 1'b0;
            dec_reason = RISK_NOTIONAL_LIMIT;
        end
    end

    // Fill arithmetic with saturation of both the position and the notional.
    always_comb begin
        fill_net_x = qty_ext_t'(fill_net);
        fill_qty_x = {2'b00, fill_qty};
        if (fill_side == SIDE_BUY) begin
            fill_sum_x = fill_net_x + fill_qty_x;
        end else begin
            fill_sum_x = fill_net_x - fill_qty_x;
        end

        if (fill_sum_x > NET_MAX) begin
            fill_net_next = NET_MAX[QTY_WIDTH:0];
        end else if (fill_sum_x < NET_MIN) begin
            fill_net_next = NET_MIN[QTY_WIDTH:0];
        end else begin
            fill_net_next = fill_sum_x[QTY_WIDTH:0];
        end

        fill_notional_sum = {1'b0, gross_q} + {1'b0, fill_notional};
        gross_next        = fill_notional_sum[NOTIONAL_WIDTH] ? '1
                                                              : fill_notional_sum[NOTIONAL_WIDTH-1:0];
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (!rst_n) begin
            // NOTE: the position array is reset explicitly because positions
            // must read as flat after reset; this forces it into flops rather
            // than a RAM, which is acceptable for at most 256 entries.
            for (int i = 0; i < NUM_SYMBOLS; i++) begin
                net_q[i] <= '0;
            end
            gross_q        <= '0;
            total_passed   <= '0;
            total_rejected <= '0;
            result_valid   <= 1'b0;
            result_passed  <= 1'b0;
            result_reason  <= RISK_OK;
            result_sym     <= '0;
        end else begin
            if (fill_valid && fill_in_range) begin
                for (int i = 0; i < NUM_SYMBOLS; i++) begin
                    if (fill_sym == SYM_WIDTH'(i)) begin
                        net_q[i] <= fill_net_next;
                    end
                end
                gross_q <= gross_next;
            end

            if (result_valid && result_ready) begin
                if (result_passed) begin
                    total_passed <= total_passed + 64'd1;
                end else begin
                    total_rejected <= total_rejected + 64'd1;
                end
            end

            // Fields are only rewritten on acceptance, so they stay stable
            // while the consumer stalls.
            if (order_accept) begin
                result_valid  <= 1'b1;
                result_passed <= dec_passed;
                result_reason <= dec_reason;
                result_sym    <= order_sym;
            end else if (result_ready) begin
                result_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_multi_symbol_position_limiter.sv
module tb_multi_symbol_position_limiter;
    import multi_symbol_position_limiter_pkg::*;

    localparam int NS = 8;
    localparam int SW = 4;
    localparam int QW = 16;
    localparam int NW = 16;

    logic                 clk;
    logic                 rst_n;
    logic                 cfg_enabled;
    logic [QW-1:0]        cfg_max_long_qty;
    logic [QW-1:0]        cfg_max_short_qty;
    logic [QW-1:0]        cfg_max_order_qty;
    logic [NW-1:0]        cfg_max_notional;
    logic                 order_valid;
    logic                 order_ready;
    logic [SW-1:0]        order_sym;
    order_side_e          order_side;
    order_type_e          order_type;
    logic [QW-1:0]        order_qty;
    logic [NW-1:0]        order_notional;
    logic                 fill_valid;
    logic [SW-1:0]        fill_sym;
    order_side_e          fill_side;
    logic [QW-1:0]        fill_qty;
    logic [NW-1:0]        fill_notional;
    logic                 result_valid;
    logic                 result_ready;
    logic                 result_passed;
    risk_reject_e         result_reason;
    logic [SW-1:0]        result_sym;
    logic [SW-1:0]        pos_rd_sym;
    logic signed [QW:0]   pos_rd_net;
    logic [NW-1:0]        gross_notional;
    logic [63:0]          total_passed;
    logic [63:0]          total_rejected;

    int checks   = 0;
    int failures = 0;

    multi_symbol_position_limiter #(
        .NUM_SYMBOLS    (NS),
        .SYM_WIDTH      (SW),
        .QTY_WIDTH      (QW),
        .NOTIONAL_WIDTH (NW)
    ) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .cfg_enabled       (cfg_enabled),
        .cfg_max_long_qty  (cfg_max_long_qty),
        .cfg_max_short_qty (cfg_max_short_qty),
        .cfg_max_order_qty (cfg_max_order_qty),
        .cfg_max_notional  (cfg_max_notional),
        .order_valid       (order_valid),
        .order_ready       (order_ready),
        .order_sym         (order_sym),
        .order_side        (order_side),
        .order_type        (order_type),
        .order_qty         (order_qty),
        .order_notional    (order_notional),
        .fill_valid        (fill_valid),
        .fill_sym          (fill_sym),
        .fill_side         (fill_side),
        .fill_qty          (fill_qty),
        .fill_notional     (fill_notional),
        .result_valid      (result_valid),
        .result_ready      (result_ready),
        .result_passed     (result_passed),
        .result_reason     (result_reason),
        .result_sym        (result_sym),
        .pos_rd_sym        (pos_rd_sym),
        .pos_rd_net        (pos_rd_net),
        .gross_notional    (gross_notional),
        .total_passed      (total_passed),
        .total_rejected    (total_rejected)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One order (and optionally a same-cycle fill) plus the expected decision.
    typedef struct {
        logic          en;
        logic [SW-1:0] sym;
        order_side_e   side;
        order_type_e   otype;
        logic [QW-1:0] qty;
        logic [NW-1:0] notl;
        logic          f_en;
        logic [SW-1:0] f_sym;
        order_side_e   f_side;
        logic [QW-1:0] f_qty;
        logic [NW-1:0] f_notl;
        logic          exp_passed;
        risk_reject_e  exp_reason;
    } vec_t;

    localparam int NVEC = 21;
    vec_t vecs [NVEC];

    function automatic vec_t mk(
        input logic en, input int sym, input order_side_e side, input order_type_e otype,
        input int qty, input int notl,
        input logic f_en, input int f_sym, input order_side_e f_side, input int f_qty, input int f_notl,
        input logic exp_passed, input risk_reject_e exp_reason);
        vec_t v;
        v.en = en; v.sym = SW'(sym); v.side = side; v.otype = otype;
        v.qty = QW'(qty); v.notl = NW'(notl);
        v.f_en = f_en; v.f_sym = SW'(f_sym); v.f_side = f_side;
        v.f_qty = QW'(f_qty); v.f_notl = NW'(f_notl);
        v.exp_passed = exp_passed; v.exp_reason = exp_reason;
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, $signed(act), $signed(exp));
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_pos(input string name, input int sym, input longint exp);
        pos_rd_sym = SW'(sym);
        #1;
        check(name, longint'(pos_rd_net), exp);
    endtask

    task automatic do_fill(input int sym, input order_side_e side, input int qty, input int notl);
        fill_sym      = SW'(sym);
        fill_side     = side;
        fill_qty      = QW'(qty);
        fill_notional = NW'(notl);
        fill_valid    = 1'b1;
        step();
        fill_valid    = 1'b0;
    endtask

    task automatic drive_order(input int sym, input order_side_e side, input int qty, input int notl);
        order_sym      = SW'(sym);
        order_side     = side;
        order_type     = ORDER_NEW;
        order_qty      = QW'(qty);
        order_notional = NW'(notl);
        order_valid    = 1'b1;
    endtask

    initial begin
        int exp_pass;
        int exp_rej;

        // Limits: long 100, short 50, order 40, notional 1000.
        // Starting state for the table: net2=100, gross=300, all else 0.
        vecs[0]  = mk(1, 2, SIDE_BUY,  ORDER_NEW,    1,    1,    0, 0, SIDE_BUY,  0,  0,    0, RISK_POSITION_LIMIT);
        vecs[1]  = mk(1, 3, SIDE_BUY,  ORDER_NEW,    1,    1,    0, 0, SIDE_BUY,  0,  0,    1, RISK_OK);
        vecs[2]  = mk(1, 0, SIDE_SELL, ORDER_NEW,    41,   1,    0, 0, SIDE_BUY,  0,  0,    0, RISK_ORDER_SIZE);
        vecs[3]  = mk(1, 2, SIDE_BUY,  ORDER_NEW,    41,   1,    0, 0, SIDE_BUY,  0,  0,    0, RISK_ORDER_SIZE);
        vecs[4]  = mk(1, 2, SIDE_BUY,  ORDER_CANCEL, 1000, 5000, 0, 0, SIDE_BUY,  0,  0,    1, RISK_OK);
        vecs[5]  = mk(1, 8, SIDE_BUY,  ORDER_CANCEL, 1,    1,    0, 0, SIDE_BUY,  0,  0,    0, RISK_POSITION_LIMIT);
        vecs[6]  = mk(1, 0, SIDE_SELL, ORDER_NEW,    40,   700,  0, 0, SIDE_BUY,  0,  0,    1, RISK_OK);
        vecs[7]  = mk(1, 0, SIDE_SELL, ORDER_NEW,    40,   701,  0, 0, SIDE_BUY,  0,  0,    0, RISK_NOTIONAL_LIMIT);
        vecs[8]  = mk(0, 0, SIDE_BUY,  ORDER_NEW,    41,   5000, 0, 0, SIDE_BUY,  0,  0,    1, RISK_OK);
        vecs[9]  = mk(0, 8, SIDE_BUY,  ORDER_NEW,    1,    1,    0, 0, SIDE_BUY,  0,  0,    0, RISK_POSITION_LIMIT);
        // Same-cycle fill is not seen by the order: net0 still 0 -> -40 ok.
        vecs[10] = mk(1, 0, SIDE_SELL, ORDER_NEW,    40,   0,    1, 0, SIDE_SELL, 40, 0,    1, RISK_OK);
        vecs[11] = mk(1, 0, SIDE_SELL, ORDER_NEW,    40,   0,    0, 0, SIDE_BUY,  0,  0,    0, RISK_POSITION_LIMIT);
        vecs[12] = mk(1, 0, SIDE_SELL, ORDER_NEW,    10,   0,    0, 0, SIDE_BUY,  0,  0,    1, RISK_OK);
        vecs[13] = mk(1, 0, SIDE_SELL, ORDER_NEW,    11,   0,    0, 0, SIDE_BUY,  0,  0,    0, RISK_POSITION_LIMIT);
        // Fill lifts gross to 990 but the order still sees 300.
        vecs[14] = mk(1, 6, SIDE_BUY,  ORDER_NEW,    1,    700,  1, 1, SIDE_BUY,  90, 690,  1, RISK_OK);
        vecs[15] = mk(1, 1, SIDE_BUY,  ORDER_NEW,    10,   0,    1, 1, SIDE_BUY,  10, 0,    1, RISK_OK);
        vecs[16] = mk(1, 1, SIDE_BUY,  ORDER_NEW,    1,    0,    0, 0, SIDE_BUY,  0,  0,    0, RISK_POSITION_LIMIT);
        vecs[17] = mk(1, 7, SIDE_BUY,  ORDER_NEW,    1,    11,   0, 0, SIDE_BUY,  0,  0,    0, RISK_NOTIONAL_LIMIT);
        vecs[18] = mk(1, 7, SIDE_BUY,  ORDER_NEW,    1,    10,   0, 0, SIDE_BUY,  0,  0,    1, RISK_OK);
        // Out-of-range fill is dropped entirely, notional included.
        vecs[19] = mk(1, 7, SIDE_BUY,  ORDER_NEW,    1,    11,   1, 8, SIDE_BUY,  5,  1000, 0, RISK_NOTIONAL_LIMIT);
        vecs[20] = mk(1, 7, SIDE_SELL, ORDER_NEW,    40,   10,   0, 0, SIDE_BUY,  0,  0,    1, RISK_OK);

        cfg_enabled       = 1'b1;
        cfg_max_long_qty  = QW'(100);
        cfg_max_short_qty = QW'(50);
        cfg_max_order_qty = QW'(40);
        cfg_max_notional  = NW'(1000);
        result_ready      = 1'b1;
        pos_rd_sym        = '0;

        // Reset with traffic present: both must be ignored.
        rst_n = 1'b0;
        drive_order(3, SIDE_BUY, 1, 0);
        fill_sym = SW'(2); fill_side = SIDE_BUY; fill_qty = QW'(5); fill_notional = NW'(5);
        fill_valid = 1'b1;
        step();
        step();
        rst_n       = 1'b1;
        order_valid = 1'b0;
        fill_valid  = 1'b0;
        #1;
        check("rst_order_ready", 64'(order_ready), 64'd1);
        step();
        check("rst_result_valid", 64'(result_valid), 64'd0);
        check("rst_result_passed", 64'(result_passed), 64'd0);
        check("rst_result_reason", 64'(result_reason), 64'(RISK_OK));
        check("rst_result_sym", 64'(result_sym), 64'd0);
        check("rst_gross", 64'(gross_notional), 64'd0);
        check("rst_total_passed", total_passed, 64'd0);
        check("rst_total_rejected", total_rejected, 64'd0);
        check_pos("rst_pos2", 2, 0);

        do_fill(2, SIDE_BUY, 30, 100);
        do_fill(2, SIDE_BUY, 40, 100);
        do_fill(2, SIDE_BUY, 30, 100);
        check_pos("fill_pos2", 2, 100);
        check("fill_gross", 64'(gross_notional), 64'd300);

        exp_pass = 0;
        exp_rej  = 0;
        for (int i = 0; i < NVEC; i++) begin
            check($sformatf("vec%0d_order_ready", i), 64'(order_ready), 64'd1);
            cfg_enabled    = vecs[i].en;
            order_sym      = vecs[i].sym;
            order_side     = vecs[i].side;
            order_type     = vecs[i].otype;
            order_qty      = vecs[i].qty;
            order_notional = vecs[i].notl;
            order_valid    = 1'b1;
            fill_valid     = vecs[i].f_en;
            fill_sym       = vecs[i].f_sym;
            fill_side      = vecs[i].f_side;
            fill_qty       = vecs[i].f_qty;
            fill_notional  = vecs[i].f_notl;
            step();
            order_valid = 1'b0;
            fill_valid  = 1'b0;
            cfg_enabled = 1'b1;
            check($sformatf("vec%0d_valid", i), 64'(result_valid), 64'd1);
            check($sformatf("vec%0d_passed", i), 64'(result_passed), 64'(vecs[i].exp_passed));
            check($sformatf("vec%0d_reason", i), 64'(result_reason), 64'(vecs[i].exp_reason));
            check($sformatf("vec%0d_sym", i), 64'(result_sym), 64'(vecs[i].sym));
            if (vecs[i].exp_passed) exp_pass++;
            else                    exp_rej++;
        end
        step();
        check("tbl_idle_valid", 64'(result_valid), 64'd0);
        check("tbl_total_passed", total_passed, 64'(exp_pass));
        check("tbl_total_rejected", total_rejected, 64'(exp_rej));
        check_pos("tbl_pos0", 0, -40);
        check_pos("tbl_pos1", 1, 100);
        check_pos("tbl_pos2", 2, 100);
        check_pos("tbl_pos7", 7, 0);
        check_pos("tbl_pos_oor", 9, 0);
        check("tbl_gross", 64'(gross_notional), 64'd990);

        // Backpressure: hold result_ready low for three cycles.
        result_ready = 1'b0;
        drive_order(3, SIDE_BUY, 1, 0);
        step();
        check("bp_first_valid", 64'(result_valid), 64'd1);
        drive_order(5, SIDE_BUY, 41, 0);
        for (int k = 0; k < 3; k++) begin
            check($sformatf("bp%0d_order_ready", k), 64'(order_ready), 64'd0);
            check($sformatf("bp%0d_sym", k), 64'(result_sym), 64'd3);
            check($sformatf("bp%0d_passed", k), 64'(result_passed), 64'd1);
            check($sformatf("bp%0d_reason", k), 64'(result_reason), 64'(RISK_OK));
            check($sformatf("bp%0d_total_passed", k), total_passed, 64'(exp_pass));
            step();
        end
        result_ready = 1'b1;
        #1;
        check("bp_release_order_ready", 64'(order_ready), 64'd1);
        step();
        order_valid = 1'b0;
        check("bp_release_total_passed", total_passed, 64'(exp_pass + 1));
        check("bp_next_sym", 64'(result_sym), 64'd5);
        check("bp_next_reason", 64'(result_reason), 64'(RISK_ORDER_SIZE));
        step();
        check("bp_next_total_rejected", total_rejected, 64'(exp_rej + 1));
        check("bp_drain_valid", 64'(result_valid), 64'd0);

        // Reset while a result is stalled.
        result_ready = 1'b0;
        drive_order(3, SIDE_BUY, 1, 0);
        step();
        check("mid_rst_pre_valid", 64'(result_valid), 64'd1);
        rst_n = 1'b0;
        fill_sym = SW'(3); fill_side = SIDE_BUY; fill_qty = QW'(7); fill_notional = NW'(7);
        fill_valid = 1'b1;
        step();
        check("mid_rst_valid", 64'(result_valid), 64'd0);
        check("mid_rst_passed", 64'(result_passed), 64'd0);
        check("mid_rst_reason", 64'(result_reason), 64'(RISK_OK));
        check("mid_rst_sym", 64'(result_sym), 64'd0);
        check("mid_rst_total_passed", total_passed, 64'd0);
        check("mid_rst_total_rejected", total_rejected, 64'd0);
        check("mid_rst_gross", 64'(gross_notional), 64'd0);
        check_pos("mid_rst_pos1", 1, 0);
        check_pos("mid_rst_pos3", 3, 0);
        rst_n        = 1'b1;
        order_valid  = 1'b0;
        fill_valid   = 1'b0;
        result_ready = 1'b1;
        #1;
        check("mid_rst_order_ready", 64'(order_ready), 64'd1);
        step();

        // Saturation of positions and gross notional.
        do_fill(3, SIDE_BUY, 65535, 65535);
        check_pos("sat_pos3_max", 3, 65535);
        check("sat_gross_max", 64'(gross_notional), 64'd65535);
        do_fill(3, SIDE_BUY, 5, 1);
        check_pos("sat_pos3_hold", 3, 65535);
        check("sat_gross_hold", 64'(gross_notional), 64'd65535);
        do_fill(4, SIDE_SELL, 65535, 0);
        do_fill(4, SIDE_SELL, 65535, 0);
        check_pos("sat_pos4_min", 4, -65535);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/multi_symbol_position_limiter.md
MULTI_SYMBOL_POSITION_LIMITER -- requirements
Module: multi_symbol_position_limiter

Interface
REQ-001 Parameter NUM_SYMBOLS, default 8, number of independently tracked instruments (1..256).
REQ-002 Parameter SYM_WIDTH, default $clog2(NUM_SYMBOLS) (min 1), symbol-id width.
REQ-003 Parameter QTY_WIDTH, default 64, unsigned order/fill quantity width.
REQ-004 Parameter NOTIONAL_WIDTH, default 64, unsigned notional width.
REQ-005 clk  in  1  sole clock, all state on rising edge.
REQ-006 rst_n  in  1  reset, synchronous, active-low.
REQ-007 cfg_enabled  in  1 (0: every order passes; state still updates); cfg_max_long_qty, cfg_max_short_qty, cfg_max_order_qty  in  QTY_WIDTH; cfg_max_notional  in  NOTIONAL_WIDTH (global gross limit).
REQ-008 order_valid in 1, order_ready out 1, order_sym in SYM_WIDTH, order_side in order_side_e, order_type in order_type_e, order_qty in QTY_WIDTH, order_notional in NOTIONAL_WIDTH.
REQ-009 fill_valid in 1, fill_sym in SYM_WIDTH, fill_side in order_side_e, fill_qty in QTY_WIDTH, fill_notional in NOTIONAL_WIDTH.
REQ-010 result_valid out 1, result_ready in 1, result_passed out 1, result_reason out risk_reject_e, result_sym out SYM_WIDTH.
REQ-011 pos_rd_sym in SYM_WIDTH; pos_rd_net out signed QTY_WIDTH+1 (combinational read of net position); gross_notional out NOTIONAL_WIDTH.
REQ-012 total_passed, total_rejected  out  64  decision counters.

Function
REQ-013 Per symbol: signed net position, QTY_WIDTH+1 bits (positive long, negative short); one global gross_notional register.
REQ-014 order_ready = !result_valid || result_ready; order accepted when order_valid && order_ready.
REQ-015 Latency 1: decision for an order accepted in cycle N is presented in cycle N+1 with result_valid=1; result fields held stable until result_valid && result_ready.
REQ-016 Back-to-back: acceptance with result_ready=1 sustains one decision per cycle.
REQ-017 Checks on ORDER_NEW: order_qty <= cfg_max_order_qty; BUY: net+order_qty <= cfg_max_long_qty; SELL: net-order_qty >= -cfg_max_short_qty; gross_notional+order_notional <= cfg_max_notional; all arithmetic QTY_WIDTH+2 / NOTIONAL_WIDTH+1 bits, no wrap.
REQ-018 ORDER_CANCEL always passes; cfg_enabled=0 -> passed=1, reason RISK_OK.
REQ-019 Reject priority: RISK_ORDER_SIZE, then RISK_POSITION_LIMIT, then RISK_NOTIONAL_LIMIT; passed -> RISK_OK.
REQ-020 order_sym >= NUM_SYMBOLS: rejected, RISK_POSITION_LIMIT, regardless of cfg_enabled or type.
REQ-021 Checks use registered state at acceptance cycle; a fill in the same cycle (any symbol) is not visible to that order.
REQ-022 Fill (fill_valid=1): BUY adds fill_qty to net[fill_sym], SELL subtracts; result saturates at +/-(2^QTY_WIDTH-1); gross_notional += fill_notional, saturating at all-ones.
REQ-023 fill_sym >= NUM_SYMBOLS: fill ignored entirely, including notional.
REQ-024 Order decisions never modify positions; only fills do.
REQ-025 total_passed / total_rejected increment in the cycle the decision is consumed (result_valid && result_ready); 64-bit wrap permitted.
REQ-026 pos_rd_net reflects registered state (pre-update in a fill cycle); out-of-range pos_rd_sym returns 0.

Reset
REQ-027 While rst_n=0 at a rising edge: all net positions, gross_notional, counters cleared to 0; result_valid=0, result_passed=0, result_reason=RISK_OK, result_sym=0.
REQ-028 Reset mid-handshake discards any pending result; order_ready=1 in the first cycle after reset release.
REQ-029 Orders and fills presented while rst_n=0 are ignored.

Verification
REQ-030 Limits long=100, short=50, order=40, notional=1000; sym 2 BUY fills 30+40+30 -> pos_rd_net(2)=100; BUY 1 on sym 2 -> passed=0, RISK_POSITION_LIMIT; sym 3 BUY 1 -> passed=1.
REQ-031 SELL 41 on sym 0 with net 0 -> RISK_ORDER_SIZE (priority over position); SELL 40 twice after fills -> second yields net -80 rejection when short limit 50.
REQ-032 gross_notional=990, order_notional=11 -> RISK_NOTIONAL_LIMIT; order_notional=10 -> passed.
REQ-033 Hold result_ready=0 three cycles: order_ready=0, result fields stable, counters unchanged; release -> counter +1 in that cycle, new order accepted same cycle.
REQ-034 Same-cycle fill BUY 10 and order BUY 10 on sym 1 with net 90, long limit 100 -> order passes (pre-fill state); net becomes 100.
REQ-035 Assert rst_n=0 while result_valid=1 with result_ready=0 -> next cycle all outputs at reset values; order_sym=NUM_SYMBOLS and fill_sym=NUM_SYMBOLS -> reject/ignore per REQ-020/REQ-023.
